// File: rtl/comb_sweep_ctrl.sv
// comb_sweep_ctrl: walks a 4-bit code 0..15 into four combinational
// implementations, waits SETTLE_CYC cycles, then checks that all four
// results agree with the structural one (res[0]). It accumulates a
// mismatch count, the first failing code and the structural truth table.
module comb_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  drv,
  input  logic [3:0]  res,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_cnt,
  output logic [3:0]  first_err,
  output logic [15:0] truth
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_W = 4'(SETTLE_CYC);

  // True when any implementation output disagrees with the structural one.
  function automatic logic is_mismatch(input logic [3:0] r);
    return (r != {4{r[0]}});
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  code_r, code_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [3:0]  drv_r, drv_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        pass_r, pass_s;
  logic [4:0]  err_cnt_r, err_cnt_s;
  logic [3:0]  first_err_r, first_err_s;
  logic [15:0] truth_r, truth_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = DRIVE;
        else       state_s = IDLE;
      end
      DRIVE: begin
        if (SETTLE_CYC != 32'd0) state_s = SETTLE;
        else                     state_s = CHECK;
      end
      SETTLE: begin
        if (cnt_r == 4'd0) state_s = CHECK;
        else               state_s = SETTLE;
      end
      CHECK: begin
        if (code_r == 4'd15) state_s = FINISH;
        else                 state_s = DRIVE;
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath and output next values; all outputs come straight from flops.
  always_comb begin
    code_s      = code_r;
    cnt_s       = cnt_r;
    drv_s       = drv_r;
    pass_s      = pass_r;
    err_cnt_s   = err_cnt_r;
    first_err_s = first_err_r;
    truth_s     = truth_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          code_s      = 4'd0;
          err_cnt_s   = 5'd0;
          first_err_s = 4'd0;
          truth_s     = 16'd0;
          pass_s      = 1'b0;
        end else begin
          code_s = code_r;
        end
      end
      DRIVE: begin
        drv_s = code_r;
        // Loaded with one less so SETTLE occupies exactly SETTLE_CYC cycles.
        cnt_s = SETTLE_W - 4'd1;
      end
      SETTLE: begin
        if (cnt_r != 4'd0) cnt_s = cnt_r - 4'd1;
        else               cnt_s = cnt_r;
      end
      CHECK: begin
        truth_s[code_r] = res[0];
        if (is_mismatch(res)) begin
          err_cnt_s = err_cnt_r + 5'd1;
          if (err_cnt_r == 5'd0) first_err_s = code_r;
          else                   first_err_s = first_err_r;
        end else begin
          err_cnt_s = err_cnt_r;
        end
        if (code_r == 4'd15) begin
          pass_s = (err_cnt_s == 5'd0);
        end else begin
          code_s = code_r + 4'd1;
        end
      end
      FINISH: begin
        cnt_s = 4'd0;
      end
      default: begin
        code_s = 4'd0;
      end
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == FINISH);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_r      <= 4'd0;
      cnt_r       <= 4'd0;
      drv_r       <= 4'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_cnt_r   <= 5'd0;
      first_err_r <= 4'd0;
      truth_r     <= 16'd0;
    end else begin
      code_r      <= code_s;
      cnt_r       <= cnt_s;
      drv_r       <= drv_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      pass_r      <= pass_s;
      err_cnt_r   <= err_cnt_s;
      first_err_r <= first_err_s;
      truth_r     <= truth_s;
    end
  end

  assign drv       = drv_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_cnt   = err_cnt_r;
  assign first_err = first_err_r;
  assign truth     = truth_r;

endmodule
